// File: rtl/pdm_cic_decimator_if.sv
// PDM-in / PCM-out port bundle for the CIC decimator.
// The master modport drives the PDM strobe and bit; the slave modport returns PCM samples.
interface pdm_cic_decimator_if #(
  parameter int LOG2_DECIM = 6,
  parameter int OUT_W      = 16
);
  logic                    pdm_en;
  logic                    pdm_data;
  logic signed [OUT_W-1:0] pcm_sample;
  logic                    pcm_valid;
  logic [LOG2_DECIM-1:0]   frame_cnt;

  modport master (
    output pdm_en,
    output pdm_data,
    input  pcm_sample,
    input  pcm_valid,
    input  frame_cnt
  );

  modport slave (
    input  pdm_en,
    input  pdm_data,
    output pcm_sample,
    output pcm_valid,
    output frame_cnt
  );
endinterface

// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator turning a strobed 1-bit PDM stream into signed PCM.
// Integrators advance on each PDM strobe; combs and the saturating output stage run once per frame.
module pdm_cic_decimator #(
  parameter int LOG2_DECIM = 6,
  parameter int OUT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  pdm_cic_decimator_if.slave bus
);

  localparam int ACC_W = 3 * LOG2_DECIM + 2;
  // Drops the 3*L+1 bit magnitude of c3 down to OUT_W bits; assumes OUT_W <= 3*L+1.
  localparam int SHIFT = 3 * LOG2_DECIM + 1 - OUT_W;

  localparam logic signed [ACC_W-1:0] ACC_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_M_ONE = {ACC_W{1'b1}};
  localparam logic signed [ACC_W-1:0] ACC_Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LOG2_DECIM-1:0]   CNT_LAST  = {LOG2_DECIM{1'b1}};
  localparam logic [LOG2_DECIM-1:0]   CNT_ONE   = {{(LOG2_DECIM-1){1'b0}}, 1'b1};

  function automatic logic signed [ACC_W-1:0] pdm_to_x(input logic bit_in);
    if (bit_in) begin
      return ACC_ONE;
    end else begin
      return ACC_M_ONE;
    end
  endfunction

  logic signed [ACC_W-1:0] int1_r, int2_r, int3_r;
  logic signed [ACC_W-1:0] dly1_r, dly2_r, dly3_r;
  logic [LOG2_DECIM-1:0]   count_r;
  logic                    dec_tick_r;
  logic signed [OUT_W-1:0] pcm_sample_r;
  logic                    pcm_valid_r;

  logic signed [ACC_W-1:0] int1_nxt_s, int2_nxt_s, int3_nxt_s;
  logic signed [ACC_W-1:0] comb1_s, comb2_s, comb3_s;
  logic signed [ACC_W-1:0] scaled_s;
  logic signed [OUT_W-1:0] sat_s;

  // Integrator cascade and comb/scale/saturate datapath.
  always_comb begin
    int1_nxt_s = int1_r + pdm_to_x(bus.pdm_data);
    int2_nxt_s = int2_r + int1_nxt_s;
    int3_nxt_s = int3_r + int2_nxt_s;
    // int3_r already holds the frame's last bit when dec_tick_r is high.
    comb1_s    = int3_r - dly1_r;
    comb2_s    = comb1_s - dly2_r;
    comb3_s    = comb2_s - dly3_r;
    scaled_s   = comb3_s >>> SHIFT;
    sat_s      = scaled_s[OUT_W-1:0];
    if (scaled_s > ACC_Y_MAX) begin
      sat_s = OUT_MAX;
    end else if (scaled_s < ACC_Y_MIN) begin
      sat_s = OUT_MIN;
    end else begin
      sat_s = scaled_s[OUT_W-1:0];
    end
  end

  // Integrators, frame counter and the registered decimation tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      int1_r     <= '0;
      int2_r     <= '0;
      int3_r     <= '0;
      count_r    <= '0;
      dec_tick_r <= 1'b0;
    end else begin
      if (bus.pdm_en) begin
        int1_r  <= int1_nxt_s;
        int2_r  <= int2_nxt_s;
        int3_r  <= int3_nxt_s;
        count_r <= count_r + CNT_ONE;
      end
      dec_tick_r <= bus.pdm_en && (count_r == CNT_LAST);
    end
  end

  // Comb delays and output register, updated once per decimation tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly1_r       <= '0;
      dly2_r       <= '0;
      dly3_r       <= '0;
      pcm_sample_r <= '0;
      pcm_valid_r  <= 1'b0;
    end else begin
      pcm_valid_r <= dec_tick_r;
      if (dec_tick_r) begin
        dly1_r       <= int3_r;
        dly2_r       <= comb1_s;
        dly3_r       <= comb2_s;
        pcm_sample_r <= sat_s;
      end
    end
  end

  assign bus.pcm_sample = pcm_sample_r;
  assign bus.pcm_valid  = pcm_valid_r;
  assign bus.frame_cnt  = count_r;

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Consumes the 1-bit PDM stream from the microphone capture stage and produces decimated signed PCM samples.
- Uses a 3rd-order CIC decimator: integrators run at the PDM bit rate, combs run at the output rate.
- Sits directly downstream of the mic shift/capture stage and feeds the PCM buffer / UART / visualisation logic.
- Runs on the system clock; the PDM bit rate is conveyed by a one-cycle enable strobe, not by a separate clock.

Parameters:
- LOG2_DECIM, 6: decimation ratio R = 2^LOG2_DECIM (64 → 2 MHz PDM gives 31.25 kHz PCM).
- OUT_W, 16: PCM output width, signed two's complement.
- ACC_W is derived, not a parameter: ACC_W = 3*LOG2_DECIM + 2 (20 at default).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pdm_en  input  1  one-cycle strobe: pdm_data holds a valid new PDM bit this cycle; may be high on consecutive cycles.
- pdm_data  input  1  PDM bit; 1 → +1, 0 → −1.
- pcm_sample  output  OUT_W  decimated signed PCM sample.
- pcm_valid  output  1  one-cycle pulse: pcm_sample updated this cycle.
- frame_cnt  output  LOG2_DECIM  bits accepted in the current decimation frame (0..R−1); for debug/LEDs.

Behaviour:
- Reset (reset high at a rising edge):
  - Integrators I1..I3, comb delays D1..D3, decimation counter, pcm_sample and pcm_valid all go to 0 at that edge.
  - Applies equally mid-frame; a partially accumulated frame is discarded.
  - pdm_en is ignored while reset is high.
- Input mapping: x = +1 if pdm_data = 1, else −1, sign-extended to ACC_W.
- Integrators: on each clk with pdm_en = 1, I1 ← I1 + x, I2 ← I2 + I1_new, I3 ← I3 + I2_new. This is a cascade within the same edge; combinational chaining is permitted. All three hold when pdm_en = 0.
- Integrator arithmetic is modular ACC_W-bit wrap-around with no saturation; wrap is required for CIC correctness.
- Decimation counter:
  - Increments on each pdm_en and wraps from R−1 to 0.
  - When pdm_en = 1 and count = R−1, a registered decimation tick dec_tick is set for the next cycle.
- Combs, on the cycle dec_tick = 1, using s = I3 (which already includes the frame's last bit):
  - c1 = s − D1, c2 = c1 − D2, c3 = c2 − D3.
  - D1 ← s, D2 ← c1, D3 ← c2.
  - All subtraction is ACC_W-bit modular.
- Output scaling:
  - y = c3 arithmetically shifted right by (3*LOG2_DECIM + 1 − OUT_W).
  - Saturate y to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. The only clipping case is +full-scale +2^(3L) mapping to +2^(OUT_W−1), which clips to max.
  - Registered into pcm_sample on the same edge as the comb update.
- Latency: pcm_valid is high exactly 2 clk after the edge at which the frame's R-th pdm_en is sampled (one cycle for dec_tick, one for the comb/output register). It is high for exactly one cycle, and pcm_sample holds until the next pulse.
- Back-to-back pdm_en every cycle is legal. pcm_valid still pulses once per R bits; dec_tick overlapping the next frame's pdm_en must not lose or double-count a bit.
- Settling: the first 3 output samples after reset are transient. Outputs from sample 4 onward are exact for stationary input.
- The consumer has no backpressure; a missed pcm_valid is a lost sample.

Test Plan:
- Reset then 4·R bits of pdm_data = 1, with pdm_en every 4th clk → 4 pcm_valid pulses, each 2 clk after every 64th strobe. Samples 1–3 increase monotonically; sample 4 onward = 32767.
- Constant pdm_data = 0, pdm_en every cycle, ≥5 frames → sample 4 onward = −32768. pcm_valid spacing = exactly 64 clk.
- Alternating 1,0,1,0 with pdm_en every cycle → sample 4 onward = 0.
- 75% density pattern 1,1,1,0 repeated → sample 4 onward = +16384 (0.5·2^18 >> 3).
- Assert reset for 1 clk at bit 30 of frame 3, then continue all-ones → pcm_valid = 0 and pcm_sample = 0 on the next cycle. The next pcm_valid arrives 64 bits after release, and settling restarts (sample 4 after release = 32767).
- Random pdm_en gaps (0–7 idle clk) with random pdm_data vs. a bit-exact software CIC model → every pcm_sample matches, with no missing or extra pcm_valid pulses. frame_cnt equals the model's bit count mod 64 at every pdm_en.
